// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory stage: funct3 access encodings and the
// load/store sequencing states.
package riscv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// misalignment detection, and load byte/half extraction with extension.
module lsu_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  stFunct3_i,
   input  logic [1:0]  stOffset_i,
   input  logic [31:0] storeData_i,
   output logic [3:0]  byteEn_o,
   output logic [31:0] laneData_o,
   output logic        misalign_o,
   input  logic [2:0]  ldFunct3_i,
   input  logic [1:0]  ldOffset_i,
   input  logic [31:0] loadWord_i,
   output logic [31:0] loadData_o
);

   logic [7:0]  ldByte;
   logic [15:0] ldHalf;

   // Undefined funct3 codes fall back to whole-word behaviour.
   always_comb begin
      byteEn_o   = 4'b1111;
      laneData_o = storeData_i;
      misalign_o = 1'b0;
      case (stFunct3_i)
         F3_B, F3_BU: begin
            byteEn_o   = 4'b0001 << stOffset_i;
            laneData_o = {4{storeData_i[7:0]}};
         end
         F3_H, F3_HU: begin
            byteEn_o   = 4'b0011 << stOffset_i;
            laneData_o = {2{storeData_i[15:0]}};
            misalign_o = stOffset_i[0];
         end
         F3_W: misalign_o = |stOffset_i;
         default: ;
      endcase
   end

   always_comb begin
      case (ldOffset_i)
         2'd0:    ldByte = loadWord_i[7:0];
         2'd1:    ldByte = loadWord_i[15:8];
         2'd2:    ldByte = loadWord_i[23:16];
         default: ldByte = loadWord_i[31:24];
      endcase
      ldHalf = ldOffset_i[1] ? loadWord_i[31:16] : loadWord_i[15:0];
      case (ldFunct3_i)
         F3_B:    loadData_o = {{24{ldByte[7]}}, ldByte};
         F3_BU:   loadData_o = {24'd0, ldByte};
         F3_H:    loadData_o = {{16{ldHalf[15]}}, ldHalf};
         F3_HU:   loadData_o = {16'd0, ldHalf};
         default: loadData_o = loadWord_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: drives a ready-handshaked data-memory port and
// stalls the pipeline until the access completes.
module mem_access_unit
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic              RegWriteM,
   input  logic [2:0]        funct3M,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [31:0]       WriteDataM,
   output logic [31:0]       ReadDataM,
   output logic              RegWriteMW,
   output logic              StallM,
   output logic              MisalignM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        offset_q, offset_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              access;
   logic              misalignRaw;
   logic [3:0]        byteEn;
   logic [31:0]       laneData;
   logic [31:0]       loadData;

   assign access = MemReadM | MemWriteM;

   lsu_align uAlign (
      .stFunct3_i  (funct3M),
      .stOffset_i  (ALUResultM[1:0]),
      .storeData_i (WriteDataM),
      .byteEn_o    (byteEn),
      .laneData_o  (laneData),
      .misalign_o  (misalignRaw),
      .ldFunct3_i  (funct3_q),
      .ldOffset_i  (offset_q),
      .loadWord_i  (rdata_q),
      .loadData_o  (loadData)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         offset_q <= 2'd0;
         be_q     <= 4'd0;
         wdata_q  <= 32'd0;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         offset_q <= offset_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         rdata_q  <= rdata_d;
      end
   end

   // The request is latched on leaving IDLE so it stays frozen while BUSY.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      offset_d  = offset_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      funct3_d  = funct3_q;
      rdata_d   = rdata_q;
      StallM    = 1'b0;
      MisalignM = 1'b0;
      mem_req   = 1'b0;
      ReadDataM = 32'd0;
      case (state_q)
         IDLE: begin
            if (access && misalignRaw) begin
               MisalignM = 1'b1;
            end else if (access) begin
               StallM   = 1'b1;
               addr_d   = {ALUResultM[ADDR_W-1:2], 2'b00};
               offset_d = ALUResultM[1:0];
               be_d     = byteEn;
               wdata_d  = laneData;
               we_d     = MemWriteM & ~MemReadM;
               funct3_d = funct3M;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            mem_req = 1'b1;
            StallM  = 1'b1;
            if (mem_ready) begin
               rdata_d = mem_rdata;
               state_d = DONE;
            end
         end
         DONE: begin
            ReadDataM = loadData;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign RegWriteMW = RegWriteM & ~StallM & ~MisalignM;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_be     = be_q;
   assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of load/store vectors with a
// request/response scoreboard, plus hand-written reset and back-to-back cases.
module tb_mem_access_unit;
   import riscv_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM, RegWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic [31:0] ReadDataM;
   logic        RegWriteMW, StallM, MisalignM;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        rw;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          delay;
      logic [31:0] expRead;
      logic [3:0]  expBe;
      logic [31:0] expWdata;
      logic        expMis;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] expRead;
      logic        rw;
   } sb_t;

   sb_t  sbQ[$];
   vec_t vecs[16];

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .RegWriteM  (RegWriteM),
      .funct3M    (funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .RegWriteMW (RegWriteMW),
      .StallM     (StallM),
      .MisalignM  (MisalignM),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic idleInputs();
      MemReadM   = 1'b0;
      MemWriteM  = 1'b0;
      RegWriteM  = 1'b0;
      funct3M    = 3'd0;
      ALUResultM = 32'd0;
      WriteDataM = 32'd0;
      mem_ready  = 1'b0;
      mem_rdata  = 32'd0;
   endtask

   task automatic applyStimulus(input vec_t v);
      sb_t item;
      MemReadM   = v.rd;
      MemWriteM  = v.wr;
      RegWriteM  = v.rw;
      funct3M    = v.f3;
      ALUResultM = v.addr;
      WriteDataM = v.wd;
      mem_ready  = 1'b0;
      if ((v.rd || v.wr) && !v.expMis) begin
         item.addr    = v.addr & 32'hFFFF_FFFC;
         item.be      = v.expBe;
         item.wdata   = v.expWdata;
         item.we      = v.wr & ~v.rd;
         item.expRead = v.expRead;
         item.rw      = v.rw;
         sbQ.push_back(item);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "-req"},   mem_req,   0);
      checkOutput({tag, "-we"},    mem_we,    0);
      checkOutput({tag, "-addr"},  mem_addr,  0);
      checkOutput({tag, "-be"},    mem_be,    0);
      checkOutput({tag, "-wdata"}, mem_wdata, 0);
      checkOutput({tag, "-stall"}, StallM,    0);
      checkOutput({tag, "-mis"},   MisalignM, 0);
      checkOutput({tag, "-rdata"}, ReadDataM, 0);
   endtask

   // Drives one vector starting at a negedge and follows it to completion,
   // acting as the memory model by raising mem_ready after v.delay BUSY cycles.
   task automatic runVector(input int idx, input vec_t v);
      sb_t   exp;
      int    stalls;
      int    busy;
      bit    finished;
      string tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      applyStimulus(v);
      #2;
      if (!(v.rd || v.wr)) begin
         checkOutput({tag, "-nomem-stall"}, StallM, 0);
         checkOutput({tag, "-nomem-rw"}, RegWriteMW, v.rw);
         checkOutput({tag, "-nomem-rdata"}, ReadDataM, 0);
         return;
      end
      if (v.expMis) begin
         checkOutput({tag, "-mis-flag"}, MisalignM, 1);
         checkOutput({tag, "-mis-stall"}, StallM, 0);
         checkOutput({tag, "-mis-req"}, mem_req, 0);
         checkOutput({tag, "-mis-rw"}, RegWriteMW, 0);
         checkOutput({tag, "-mis-rdata"}, ReadDataM, 0);
         @(negedge clk);
         idleInputs();
         #2;
         checkOutput({tag, "-mis-clear"}, MisalignM, 0);
         checkOutput({tag, "-mis-req2"}, mem_req, 0);
         return;
      end
      exp = sbQ[0];
      checkOutput({tag, "-idle-req"}, mem_req, 0);
      stalls   = 0;
      busy     = 0;
      finished = 0;
      for (int c = 0; c < 40 && !finished; c++) begin
         if (c > 0) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #2;
         end
         if (StallM) begin
            stalls++;
            checkOutput({tag, "-stall-rw"}, RegWriteMW, 0);
            if (mem_req) begin
               checkOutput({tag, "-addr"}, mem_addr, exp.addr);
               checkOutput({tag, "-be"}, mem_be, exp.be);
               checkOutput({tag, "-wdata"}, mem_wdata, exp.wdata);
               checkOutput({tag, "-we"}, mem_we, exp.we);
               if (busy == v.delay) begin
                  mem_ready = 1'b1;
                  mem_rdata = v.rdata;
               end
               busy++;
            end
         end else begin
            finished = 1;
            checkOutput({tag, "-done-req"}, mem_req, 0);
            checkOutput({tag, "-rdata"}, ReadDataM, exp.expRead);
            checkOutput({tag, "-rw"}, RegWriteMW, exp.rw);
            void'(sbQ.pop_front());
         end
      end
      if (!finished) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s-timeout: got no completion expected completion within 40 cycles", tag);
         sbQ.delete();
      end
      checkOutput({tag, "-stall-cycles"}, stalls, v.delay + 2);
   endtask

   initial begin
      vec_t later;
      //          rd wr rw f3     addr          wd            rdata         dly expRead       be     wdata         mis
      vecs[0]  = '{1, 0, 1, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF, 32'h0,        0};
      vecs[1]  = '{1, 0, 1, F3_B,  32'h103, 32'h0,        32'h80123456, 0, 32'hFFFFFF80, 4'h8, 32'h0,        0};
      vecs[2]  = '{1, 0, 1, F3_BU, 32'h103, 32'h0,        32'h80123456, 0, 32'h00000080, 4'h8, 32'h0,        0};
      vecs[3]  = '{0, 1, 0, F3_H,  32'h022, 32'h1234ABCD, 32'h0,        3, 32'h0,        4'hC, 32'hABCDABCD, 0};
      vecs[4]  = '{1, 0, 1, F3_W,  32'h101, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1};
      vecs[5]  = '{0, 1, 0, F3_W,  32'h004, 32'h11223344, 32'h0,        1, 32'h0,        4'hF, 32'h11223344, 0};
      vecs[6]  = '{1, 0, 1, F3_H,  32'h002, 32'h0,        32'h80015678, 0, 32'hFFFF8001, 4'hC, 32'h0,        0};
      vecs[7]  = '{1, 0, 1, F3_HU, 32'h002, 32'h0,        32'h80015678, 1, 32'h00008001, 4'hC, 32'h0,        0};
      vecs[8]  = '{1, 0, 1, F3_B,  32'h101, 32'h000000A5, 32'h12347F56, 2, 32'h0000007F, 4'h2, 32'hA5A5A5A5, 0};
      vecs[9]  = '{0, 1, 0, F3_B,  32'h003, 32'h12345699, 32'h0,        0, 32'h0,        4'h8, 32'h99999999, 0};
      vecs[10] = '{0, 0, 1, F3_B,  32'h040, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0};
      vecs[11] = '{1, 0, 1, F3_H,  32'h003, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1};
      vecs[12] = '{0, 1, 0, F3_W,  32'h006, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1};
      vecs[13] = '{1, 0, 1, F3_H,  32'h000, 32'h0,        32'h1234FFFF, 0, 32'hFFFFFFFF, 4'h3, 32'h0,        0};
      vecs[14] = '{1, 1, 1, F3_W,  32'h008, 32'h55555555, 32'hCAFEF00D, 0, 32'hCAFEF00D, 4'hF, 32'h55555555, 0};
      vecs[15] = '{0, 0, 0, F3_W,  32'h000, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0};

      reset = 1'b1;
      idleInputs();
      repeat (2) @(negedge clk);
      #2;
      checkResetState("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         runVector(i, vecs[i]);
      end

      // Reset while a load is outstanding must abandon it immediately.
      @(negedge clk);
      MemReadM   = 1'b1;
      RegWriteM  = 1'b1;
      funct3M    = F3_W;
      ALUResultM = 32'h200;
      mem_ready  = 1'b0;
      @(negedge clk);
      #2;
      checkOutput("rst-busy-req", mem_req, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idleInputs();
      #2;
      checkResetState("rst-busy");

      later = '{1, 0, 1, F3_HU, 32'h31E, 32'h0, 32'hBEEF0123, 1, 32'h0000BEEF, 4'hC, 32'h0, 0};
      runVector(16, later);

      @(negedge clk);
      idleInputs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the 5-stage RV32I pipeline. It sits between the EM and MW pipeline registers. It turns the M-stage address, store data and funct3 into a byte-lane request on a ready-handshaked data-memory port, and stalls the pipeline until the memory answers. It returns aligned, sign/zero-extended load data as ReadDataM for the MW register, and gates RegWrite so the write-back stage never commits a stalled instruction.

## Interface
- Parameters:
- ADDR_W, 32, byte-address width.
- Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- MemReadM  in  1  M-stage instruction is a load.
- MemWriteM  in  1  M-stage instruction is a store.
- RegWriteM  in  1  M-stage register-write enable from EM register.
- funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultM  in  ADDR_W  effective byte address.
- WriteDataM  in  32  store data (rs2).
- ReadDataM  out  32  extended load data to MW register.
- RegWriteMW  out  1  RegWriteM & ~StallM & ~MisalignM, to MW register.
- StallM  out  1  freeze PC, FD, DE and EM registers.
- MisalignM  out  1  one-cycle misaligned-access flag.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  word address, low two bits forced to 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory accepted/completed request this cycle.
- mem_rdata  in  32  read word, valid when mem_ready=1.

## Operation
- Access = MemReadM | MemWriteM. If both are high, the access is treated as a load.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - No request is issued.
  - MisalignM=1, StallM=0, ReadDataM=0, RegWriteMW=0.
  - The FSM stays in IDLE.
- FSM states IDLE, BUSY, DONE. Request signals are registered at entry to BUSY.
  - IDLE: on an aligned access, latch addr, be, wdata and we, and go to BUSY. StallM=1 in that cycle. Otherwise StallM=0.
  - BUSY: mem_req=1, StallM=1. On mem_ready, capture mem_rdata and go to DONE. Otherwise stay in BUSY; request fields stay constant.
  - DONE: StallM=0, mem_req=0. ReadDataM comes from the captured word. Go to IDLE unconditionally. The instruction advances to W at this edge.
- Store lanes, indexed by a=addr[1:0]:
  - B: be=0001<<a, wdata={4{wd[7:0]}}.
  - H: be=0011<<a, wdata={2{wd[15:0]}}.
  - W: be=1111.
- Load extract: select byte a or half a[1] of the captured word. B/H sign-extend, BU/HU zero-extend, W passes through.
- Outside DONE, ReadDataM is 0. Non-memory instructions pass with StallM=0 and RegWriteMW=RegWriteM.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, captured data=0, StallM=0, MisalignM=0, ReadDataM=0.
- Reset takes priority in any state. A BUSY transaction is abandoned and mem_req drops after the reset edge. The memory must tolerate an abandoned request.
- Minimum latency is 3 cycles in M (IDLE, BUSY, DONE) with mem_ready on the first BUSY cycle. Each extra cycle of mem_ready low adds one stall cycle.
- mem_ready is ignored outside BUSY.
- Back-to-back memory instructions: DONE→IDLE, then the next access starts in IDLE. No request overlap.
- During stall, RegWriteMW=0, so the MW register captures a bubble each stalled cycle.

## Structure
- Shared package riscv_mem_pkg holds:
  - funct3 constants F3_B/H/W/BU/HU.
  - The state enum (IDLE, BUSY, DONE).
- Sub-module lsu_align (combinational) holds:
  - Store lane/byte-enable generation.
  - Load extract/extend.
  - Misalignment detection.
- The FSM and registers stay in mem_access_unit.

## Test plan
- LW, addr 0x100, mem_ready first BUSY cycle, rdata 0xDEADBEEF:
  - mem_addr=0x100, be=1111.
  - StallM high 2 cycles.
  - DONE cycle: ReadDataM=0xDEADBEEF, RegWriteMW=1.
- LB addr 0x103 / LBU addr 0x103, rdata 0x80123456:
  - LB: ReadDataM=0xFFFFFF80.
  - LBU: ReadDataM=0x00000080.
- SH addr 0x22, WriteDataM 0x1234ABCD, mem_ready delayed 3 cycles:
  - be=1100, wdata=0xABCDABCD, we=1, held stable.
  - StallM high 5 cycles.
  - RegWriteMW=0 throughout.
- LW addr 0x101:
  - No mem_req, MisalignM=1 for one cycle, StallM=0, RegWriteMW=0.
- Reset asserted in BUSY:
  - Next cycle state=IDLE, mem_req=0, StallM=0.
  - A later load completes normally.
- Back-to-back SW then LH addr 0x2, rdata 0x8001xxxx:
  - No overlapping requests.
  - LH ReadDataM=0xFFFF8001.
